rptr_ctrl_non2n: RTL and testbench

Read-domain pointer controller for asynchronous FIFOs whose depth is not a power of two. It keeps the read address inside a centred window of the 2^PTR_WIDTH address space and adds a lap bit to tell full from empty. Pointers cross domains as a single-bit-change Gray code. It synchronises the write pointer and produces registered empty, almost-empty, fill level and underflow status. It sits between the dual-port RAM read port and the consumer, paired with the matching write-side controller.

---
 rtl/rptr_ctrl_non2n.sv | 142 ++++++++++++++
 tb/tb_rptr_ctrl_non2n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_ctrl_non2n.sv
// Read-side pointer controller for asynchronous FIFOs with a non-power-of-two depth.
// The read address lives in a window centred in the RAM; a lap bit separates full from empty.
module rptr_ctrl_non2n #(
   parameter int FIFO_DEPTH  = 520,
   parameter int PTR_WIDTH   = 10,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 4,
   localparam int MEM_SIZE   = 1 << PTR_WIDTH,
   localparam int START_ADDR = MEM_SIZE/2 - FIFO_DEPTH/2,
   localparam int END_ADDR   = MEM_SIZE/2 + FIFO_DEPTH/2 - 1,
   localparam int LVL_W      = $clog2(FIFO_DEPTH+1)
)(
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 r_en,
   input  logic [PTR_WIDTH:0]   wgray_async,
   input  logic                 clr_underflow,
   output logic [PTR_WIDTH-1:0] raddr,
   output logic [PTR_WIDTH:0]   rgray,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [LVL_W-1:0]     rlevel,
   output logic                 underflow
);

   localparam logic [PTR_WIDTH-1:0] START_A  = PTR_WIDTH'(START_ADDR);
   localparam logic [PTR_WIDTH-1:0] END_A    = PTR_WIDTH'(END_ADDR);
   localparam logic [PTR_WIDTH-1:0] START_G  = START_A ^ (START_A >> 1);
   localparam logic [PTR_WIDTH:0]   RST_CODE = {1'b0, START_G};
   localparam logic [LVL_W-1:0]     AE_T     = LVL_W'(AE_THRESH);
   localparam logic [LVL_W-1:0]     DEPTH_L  = LVL_W'(FIFO_DEPTH);

   // The lap bit also flips the Gray MSB, so the END->START wrap changes only the lap bit.
   function automatic logic [PTR_WIDTH:0] encode(input logic [PTR_WIDTH-1:0] addr,
                                                 input logic                 lap);
      logic [PTR_WIDTH-1:0] g;
      g = addr ^ (addr >> 1);
      return {lap, g[PTR_WIDTH-1] ^ lap, g[PTR_WIDTH-2:0]};
   endfunction

   function automatic logic [PTR_WIDTH-1:0] decode_addr(input logic [PTR_WIDTH:0] c);
      logic [PTR_WIDTH-1:0] g;
      logic [PTR_WIDTH-1:0] b;
      g = {c[PTR_WIDTH-1] ^ c[PTR_WIDTH], c[PTR_WIDTH-2:0]};
      b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
      for (int i = PTR_WIDTH-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // The true level never exceeds FIFO_DEPTH < 2^LVL_W, so modulo-2^LVL_W arithmetic is exact.
   function automatic logic [LVL_W-1:0] fill_level(input logic [PTR_WIDTH-1:0] wa,
                                                   input logic                 wl,
                                                   input logic [PTR_WIDTH-1:0] ra,
                                                   input logic                 rl);
      logic [LVL_W-1:0] lvl;
      lvl = LVL_W'(wa) - LVL_W'(ra);
      if (wl != rl) begin
         lvl = lvl + DEPTH_L;
      end
      return lvl;
   endfunction

   logic                 lap;
   logic                 rd;
   logic [PTR_WIDTH-1:0] next_addr;
   logic                 next_lap;
   logic [PTR_WIDTH:0]   next_code;
   logic [PTR_WIDTH:0]   sync_q [SYNC_STAGES];
   logic [PTR_WIDTH:0]   wq;
   logic [PTR_WIDTH-1:0] waddr;
   logic                 wlap;
   logic [LVL_W-1:0]     next_level;

   // Synchroniser resets to the reset pointer code so a fresh FIFO decodes as empty.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= RST_CODE;
         end
      end else begin
         sync_q[0] <= wgray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wq    = sync_q[SYNC_STAGES-1];
   assign waddr = decode_addr(wq);
   assign wlap  = wq[PTR_WIDTH];
   assign rd    = r_en & ~empty;

   // Next read pointer: advance inside the window, wrapping END back to START with a lap flip.
   always_comb begin
      next_addr = raddr;
      next_lap  = lap;
      if (rd) begin
         if (raddr == END_A) begin
            next_addr = START_A;
            next_lap  = ~lap;
         end else begin
            next_addr = raddr + PTR_WIDTH'(1);
         end
      end
   end

   assign next_code  = encode(next_addr, next_lap);
   assign next_level = fill_level(waddr, wlap, next_addr, next_lap);

   // Status flags look at the post-read pointer so a read shows up on its own edge.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         raddr        <= START_A;
         lap          <= 1'b0;
         rgray        <= RST_CODE;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rlevel       <= '0;
      end else begin
         raddr        <= next_addr;
         lap          <= next_lap;
         rgray        <= next_code;
         empty        <= (next_code == wq);
         almost_empty <= (next_level <= AE_T);
         rlevel       <= next_level;
      end
   end

   // Sticky underflow; a new offending read beats a simultaneous clear.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         underflow <= 1'b0;
      end else if (r_en & empty) begin
         underflow <= 1'b1;
      end else if (clr_underflow) begin
         underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rptr_ctrl_non2n.sv
// Scoreboard bench for rptr_ctrl_non2n: written addresses are queued and matched against
// raddr on every accepted read, with directed checks on flags, latency, wrap and reset.
module tb_rptr_ctrl_non2n;

   localparam int FIFO_DEPTH = 520;
   localparam int START_ADDR = 252;
   localparam int END_ADDR   = 771;

   logic        rclk = 1'b0;
   logic        rrst_n = 1'b0;
   logic        r_en = 1'b0;
   logic        clr_underflow = 1'b0;
   logic [10:0] wgray_async;
   logic [9:0]  raddr;
   logic [10:0] rgray;
   logic        empty;
   logic        almost_empty;
   logic [9:0]  rlevel;
   logic        underflow;

   int   checks = 0;
   int   failures = 0;
   int   expAddr[$];
   int   wa;
   logic wl;
   logic lastAcc;
   int   lastAddr;

   rptr_ctrl_non2n #(
      .FIFO_DEPTH(520), .PTR_WIDTH(10), .SYNC_STAGES(2), .AE_THRESH(4)
   ) dut (
      .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en), .wgray_async(wgray_async),
      .clr_underflow(clr_underflow), .raddr(raddr), .rgray(rgray), .empty(empty),
      .almost_empty(almost_empty), .rlevel(rlevel), .underflow(underflow)
   );

   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [10:0] code(input int addr, input logic lap);
      logic [9:0] a;
      logic [9:0] g;
      a = addr[9:0];
      g = a ^ (a >> 1);
      return {lap, g[9] ^ lap, g[8:0]};
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ren, input logic clr);
      r_en = ren;
      clr_underflow = clr;
      @(negedge rclk);
   endtask

   task automatic writeEntry();
      expAddr.push_back(wa);
      if (wa == END_ADDR) begin
         wa = START_ADDR;
         wl = ~wl;
      end else begin
         wa++;
      end
      wgray_async = code(wa, wl);
   endtask

   // One read-request cycle: pop and match the address the DUT is about to consume.
   task automatic readCycle(input logic doWrite);
      lastAcc = 1'b0;
      if (!empty) begin
         if (expAddr.size() == 0) begin
            checkOutput("sb_underrun_empty", int'(empty), 1);
         end else begin
            lastAddr = expAddr.pop_front();
            checkOutput("sb_raddr", int'(raddr), lastAddr);
            lastAcc = 1'b1;
         end
      end
      if (doWrite) writeEntry();
      applyStimulus(1'b1, 1'b0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_raddr"}, int'(raddr), START_ADDR);
      checkOutput({tag, "_rgray"}, int'(rgray), int'(code(START_ADDR, 1'b0)));
      checkOutput({tag, "_empty"}, int'(empty), 1);
      checkOutput({tag, "_aempty"}, int'(almost_empty), 1);
      checkOutput({tag, "_rlevel"}, int'(rlevel), 0);
      checkOutput({tag, "_underflow"}, int'(underflow), 0);
   endtask

   initial begin
      logic [10:0] prevGray;
      logic [10:0] diff;
      int written;
      int accepted;
      int wrapped;

      wa = START_ADDR;
      wl = 1'b0;
      lastAcc = 1'b0;
      lastAddr = 0;
      wgray_async = code(START_ADDR, 1'b0);
      @(negedge rclk);
      checkResetValues("rst");

      // Reset then read while empty: rejected, underflow set; set beats clear.
      rrst_n = 1'b1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("uf_set", int'(underflow), 1);
      checkOutput("uf_empty", int'(empty), 1);
      checkOutput("uf_rlevel", int'(rlevel), 0);
      checkOutput("uf_raddr", int'(raddr), START_ADDR);
      applyStimulus(1'b1, 1'b1);
      checkOutput("uf_set_wins", int'(underflow), 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("uf_clear", int'(underflow), 0);

      // Single write: visible after SYNC_STAGES+1 edges, consumed by one read.
      writeEntry();
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("lat_still_empty", int'(empty), 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("lat_empty", int'(empty), 0);
      checkOutput("lat_rlevel", int'(rlevel), 1);
      checkOutput("lat_aempty", int'(almost_empty), 1);
      readCycle(1'b0);
      checkOutput("one_raddr", int'(raddr), 253);
      checkOutput("one_empty", int'(empty), 1);
      checkOutput("one_rlevel", int'(rlevel), 0);
      readCycle(1'b0);
      checkOutput("held_raddr", int'(raddr), 253);
      checkOutput("held_underflow", int'(underflow), 1);
      applyStimulus(1'b0, 1'b1);

      // Streaming through a full lap: single-bit Gray steps and the END->START wrap.
      written = 0;
      wrapped = 0;
      prevGray = rgray;
      for (int cyc = 0; cyc < 900 && !(written >= 600 && expAddr.size() == 0); cyc++) begin
         if (cyc > 0) begin
            diff = rgray ^ prevGray;
            checkOutput("gray_onebit", $countones(diff), lastAcc ? 1 : 0);
            if (lastAcc && lastAddr == END_ADDR) begin
               wrapped++;
               checkOutput("wrap_raddr", int'(raddr), START_ADDR);
               checkOutput("wrap_lapbit", int'(diff), 'h400);
               checkOutput("wrap_lap1", int'(rgray[10]), 1);
            end
         end
         prevGray = rgray;
         readCycle(written < 600);
         if (written < 600) written++;
      end
      checkOutput("wrap_seen", wrapped, 1);
      checkOutput("wrap_drained", expAddr.size(), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("drain_empty", int'(empty), 1);
      checkOutput("drain_rlevel", int'(rlevel), 0);

      // Full FIFO: writer one lap ahead at the reader's reset address.
      rrst_n = 1'b0;
      r_en = 1'b0;
      clr_underflow = 1'b0;
      wa = START_ADDR;
      wl = 1'b1;
      wgray_async = code(START_ADDR, 1'b1);
      expAddr.delete();
      for (int a = START_ADDR; a <= END_ADDR; a++) expAddr.push_back(a);
      @(negedge rclk);
      checkResetValues("rst2");
      rrst_n = 1'b1;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("full_pre_rlevel", int'(rlevel), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("full_rlevel", int'(rlevel), FIFO_DEPTH);
      checkOutput("full_empty", int'(empty), 0);
      checkOutput("full_aempty", int'(almost_empty), 0);

      // Burst read to address 400, then asynchronous reset between clock edges.
      accepted = 0;
      for (int cyc = 0; cyc < 300 && accepted < 148; cyc++) begin
         readCycle(1'b0);
         if (lastAcc) accepted++;
      end
      checkOutput("burst_raddr", int'(raddr), 400);
      checkOutput("burst_rlevel", int'(rlevel), FIFO_DEPTH - 148);
      #2;
      rrst_n = 1'b0;
      #1;
      checkResetValues("async_rst");
      r_en = 1'b0;
      @(negedge rclk);
      rrst_n = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkOutput("post_rst_empty1", int'(empty), 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("post_rst_rlevel2", int'(rlevel), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("post_rst_rlevel3", int'(rlevel), FIFO_DEPTH);

      // Almost-empty: level 6 drained by continuous reads.
      rrst_n = 1'b0;
      wa = 258;
      wl = 1'b0;
      wgray_async = code(258, 1'b0);
      expAddr.delete();
      for (int a = START_ADDR; a < 258; a++) expAddr.push_back(a);
      @(negedge rclk);
      rrst_n = 1'b1;
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
      checkOutput("ae_rlevel6", int'(rlevel), 6);
      checkOutput("ae_flag6", int'(almost_empty), 0);
      checkOutput("ae_empty6", int'(empty), 0);
      for (int lvl = 5; lvl >= 0; lvl--) begin
         readCycle(1'b0);
         checkOutput("ae_rlevel", int'(rlevel), lvl);
         checkOutput("ae_flag", int'(almost_empty), (lvl <= 4) ? 1 : 0);
         checkOutput("ae_empty", int'(empty), (lvl == 0) ? 1 : 0);
      end
      readCycle(1'b0);
      checkOutput("ae_held_raddr", int'(raddr), 258);
      checkOutput("ae_underflow", int'(underflow), 1);
      checkOutput("ae_sb_left", expAddr.size(), 0);
      applyStimulus(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
